// File: rtl/fifo_axis_drain_if.sv
// Handshake bundle between the FIFO read side, the drain and the AXI-Stream consumer.
interface fifo_axis_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_mty;
  logic                  m_tvalid;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic                  m_tready;

  // Drain side: issues FIFO reads, sources the stream.
  modport master (
    output fifo_rd,
    input  fifo_q,
    input  fifo_mty,
    output m_tvalid,
    output m_tdata,
    output m_tlast,
    input  m_tready
  );

  // Environment side: the FIFO plus the downstream consumer.
  modport slave (
    input  fifo_rd,
    output fifo_q,
    output fifo_mty,
    input  m_tvalid,
    input  m_tdata,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/fifo_axis_drain.sv
// FIFO read-side drain: issues FIFO reads from registered occupancy only, absorbs the
// one-cycle FIFO read latency in a 3-entry skid buffer and frames the output stream
// into PKT_LEN-beat packets.
module fifo_axis_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_axis_drain_if.master     bus,
  output logic [15:0]           pkt_cnt
);

  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef logic [1:0] ptr_t;

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [DATA_WIDTH-1:0] mem_d [3];

  logic                  rd_issue;
  logic                  tvalid;
  logic                  tlast;
  logic                  accept;
  logic                  capture;
  logic [2:0]            pending;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue, stream outputs and handshake decode; all from registered state.
  always_comb begin
    pending  = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_issue = rst_n & ~bus.fifo_mty & (pending < 3'd3);
    tvalid   = (occ_q != 2'd0);
    tlast    = tvalid & (beat_cnt_q == LAST_BEAT);
    accept   = tvalid & bus.m_tready;
    capture  = inflight_q;
  end

  assign bus.fifo_rd  = rd_issue;
  assign bus.m_tvalid = tvalid;
  assign bus.m_tlast  = tlast;
  assign bus.m_tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
  assign pkt_cnt      = pkt_cnt_q;

  // Next-state for pointers, occupancy, in-flight flag, framing counters and buffer.
  always_comb begin
    wr_ptr_d   = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = accept  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = rd_issue;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    mem_d      = mem_q;

    case ({capture, accept})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (capture) begin
      mem_d[wr_ptr_q] = bus.fifo_q;
    end

    if (accept) begin
      if (tlast) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Buffer storage; contents are masked by occupancy so they need no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
